// File: rtl/aes_pkg.sv
// Shared definitions for the sequential AES key-schedule engine.
// Holds the mode encodings, the FSM state type, the per-mode Nk/Nr lookup,
// the rcon doubling step and RotWord.
package aes_pkg;

    typedef enum logic [1:0] {
        MODE_128 = 2'b00,
        MODE_192 = 2'b01,
        MODE_256 = 2'b10,
        MODE_ILL = 2'b11
    } aes_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_GEN   = 2'b01,
        ST_DRAIN = 2'b10
    } kx_state_e;

    // Key length in 32-bit words. The illegal mode maps to 8 so that callers
    // must still check the mode explicitly.
    function automatic logic [3:0] aes_nk(input logic [1:0] mode);
        case (mode)
            MODE_128: return 4'd4;
            MODE_192: return 4'd6;
            default:  return 4'd8;
        endcase
    endfunction

    function automatic logic [3:0] aes_nr(input logic [1:0] mode);
        case (mode)
            MODE_128: return 4'd10;
            MODE_192: return 4'd12;
            default:  return 4'd14;
        endcase
    endfunction

    // Multiply by x in GF(2^8), reduction polynomial x^8+x^4+x^3+x+1.
    function automatic logic [7:0] rcon_xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/aes_key_expand_seq_if.sv
// Request/round-key stream bundle for aes_key_expand_seq.
// slave  : the key expander (takes start/mode/key_in/rk_ready, drives the rest)
// master : the requester / round-key consumer
interface aes_key_expand_seq_if;
    logic         start;
    logic         start_ready;
    logic [1:0]   mode;
    logic [255:0] key_in;
    logic         rk_valid;
    logic         rk_ready;
    logic [127:0] rk_data;
    logic [3:0]   rk_idx;
    logic         rk_last;
    logic         busy;
    logic         err;

    modport slave (
        input  start, mode, key_in, rk_ready,
        output start_ready, rk_valid, rk_data, rk_idx, rk_last, busy, err
    );

    modport master (
        output start, mode, key_in, rk_ready,
        input  start_ready, rk_valid, rk_data, rk_idx, rk_last, busy, err
    );
endinterface

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box for one byte.
// Ports: in_i  - input byte
//        out_o - substituted byte
// Built as multiplicative inverse in GF(2^8) followed by the affine map,
// which keeps the source short instead of a 256-entry table.
module aes_sbox (
    input  logic [7:0] in_i,
    output logic [7:0] out_o
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // x^254 == x^-1 for x != 0, and 0 maps to 0 as the S-box requires.
    // 254 = 2+4+...+128, so multiply together the repeated squares.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] r;
        logic [7:0] sq;
        r  = 8'h01;
        sq = x;
        for (int k = 1; k < 8; k++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    logic [7:0] inv;

    always_comb begin
        inv   = gf_inv(in_i);
        out_o = inv
              ^ {inv[6:0], inv[7]}
              ^ {inv[5:0], inv[7:6]}
              ^ {inv[4:0], inv[7:5]}
              ^ {inv[3:0], inv[7:4]}
              ^ 8'h63;
    end

endmodule

// File: rtl/aes_key_expand_seq.sv
// Iterative AES-128/192/256 key schedule. One 32-bit schedule word per
// active cycle; every fourth word completes a 128-bit round key that is
// presented on a valid/ready stream.
// Ports: clk, rst_n (async, active low)
//        bus (slave): start/start_ready/mode/key_in request,
//                     rk_valid/rk_ready/rk_data/rk_idx/rk_last stream,
//                     busy status, err pulse on a rejected mode.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | waiting for start; start_ready high
// ST_GEN   | producing one schedule word per cycle unless the output stalls
// ST_DRAIN | all words produced, waiting for the rk_last handshake
module aes_key_expand_seq
    import aes_pkg::*;
#(
    parameter int MAX_NK = 8
) (
    input logic                 clk,
    input logic                 rst_n,
    aes_key_expand_seq_if.slave bus
);

    kx_state_e    state_q, state_d;
    // win_q[0] is w[i-Nk], win_q[Nk-1] is w[i-1]. Before the key words are
    // emitted they sit here in order and simply rotate through.
    logic [31:0]  win_q [MAX_NK];
    logic [31:0]  win_d [MAX_NK];
    logic [3:0]   nk_q, nk_d;
    logic [3:0]   nr_q, nr_d;
    logic [5:0]   i_q, i_d;
    logic [2:0]   j_q, j_d;
    logic [7:0]   rcon_q, rcon_d;
    logic [31:0]  acc_q [3];
    logic [31:0]  acc_d [3];
    logic         rk_valid_q, rk_valid_d;
    logic         rk_last_q, rk_last_d;
    logic [127:0] rk_data_q, rk_data_d;
    logic [3:0]   rk_idx_q, rk_idx_d;
    logic         err_q, err_d;

    logic         mode_ok;
    logic         handshake;
    logic         produce;
    logic         expand_phase;
    logic [31:0]  w_prev;
    logic [31:0]  sub_in;
    logic [31:0]  sub_out;
    logic [31:0]  t_word;
    logic [31:0]  new_word;

    assign mode_ok      = (bus.mode != MODE_ILL) && (int'(aes_nk(bus.mode)) <= MAX_NK);
    assign handshake    = rk_valid_q && bus.rk_ready;
    assign produce      = (state_q == ST_GEN) && !(rk_valid_q && !bus.rk_ready);
    assign expand_phase = (i_q >= {2'b00, nk_q});

    always_comb begin
        w_prev = win_q[0];
        for (int k = 0; k < MAX_NK; k++) begin
            if (4'(k) == nk_q - 4'd1) w_prev = win_q[k];
        end
    end

    assign sub_in = (j_q == 3'd0) ? rot_word(w_prev) : w_prev;

    for (genvar b = 0; b < 4; b++) begin : g_sbox
        aes_sbox u_sbox (
            .in_i  (sub_in[8*b +: 8]),
            .out_o (sub_out[8*b +: 8])
        );
    end

    always_comb begin
        t_word = w_prev;
        if (j_q == 3'd0) begin
            t_word = sub_out ^ {rcon_q, 24'h000000};
        end else if (nk_q == 4'd8 && j_q == 3'd4) begin
            t_word = sub_out;
        end
        new_word = expand_phase ? (win_q[0] ^ t_word) : win_q[0];
    end

    always_comb begin
        state_d    = state_q;
        win_d      = win_q;
        nk_d       = nk_q;
        nr_d       = nr_q;
        i_d        = i_q;
        j_d        = j_q;
        rcon_d     = rcon_q;
        acc_d      = acc_q;
        rk_valid_d = rk_valid_q;
        rk_last_d  = rk_last_q;
        rk_data_d  = rk_data_q;
        rk_idx_d   = rk_idx_q;
        err_d      = 1'b0;

        // A key produced on the same edge below overrides this clear.
        if (handshake) rk_valid_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    if (mode_ok) begin
                        for (int k = 0; k < MAX_NK; k++) begin
                            win_d[k] = bus.key_in[255-32*k -: 32];
                        end
                        nk_d    = aes_nk(bus.mode);
                        nr_d    = aes_nr(bus.mode);
                        i_d     = 6'd0;
                        j_d     = 3'd0;
                        rcon_d  = 8'h01;
                        state_d = ST_GEN;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_GEN: begin
                if (produce) begin
                    for (int k = 0; k < MAX_NK; k++) begin
                        if (4'(k) == nk_q - 4'd1) win_d[k] = new_word;
                        else                      win_d[k] = win_q[(k+1) % MAX_NK];
                    end
                    i_d = i_q + 6'd1;
                    j_d = ({1'b0, j_q} == nk_q - 4'd1) ? 3'd0 : j_q + 3'd1;
                    if (expand_phase && j_q == 3'd0) rcon_d = rcon_xtime(rcon_q);
                    case (i_q[1:0])
                        2'd0: acc_d[0] = new_word;
                        2'd1: acc_d[1] = new_word;
                        2'd2: acc_d[2] = new_word;
                        default: begin
                            rk_data_d  = {acc_q[0], acc_q[1], acc_q[2], new_word};
                            rk_idx_d   = i_q[5:2];
                            rk_last_d  = (i_q[5:2] == nr_q);
                            rk_valid_d = 1'b1;
                        end
                    endcase
                    if (i_q == {nr_q, 2'b11}) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (handshake && rk_last_q) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            for (int k = 0; k < MAX_NK; k++) win_q[k] <= 32'h0;
            nk_q       <= 4'd4;
            nr_q       <= 4'd10;
            i_q        <= 6'd0;
            j_q        <= 3'd0;
            rcon_q     <= 8'h01;
            for (int k = 0; k < 3; k++) acc_q[k] <= 32'h0;
            rk_valid_q <= 1'b0;
            rk_last_q  <= 1'b0;
            rk_data_q  <= 128'h0;
            rk_idx_q   <= 4'd0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            win_q      <= win_d;
            nk_q       <= nk_d;
            nr_q       <= nr_d;
            i_q        <= i_d;
            j_q        <= j_d;
            rcon_q     <= rcon_d;
            acc_q      <= acc_d;
            rk_valid_q <= rk_valid_d;
            rk_last_q  <= rk_last_d;
            rk_data_q  <= rk_data_d;
            rk_idx_q   <= rk_idx_d;
            err_q      <= err_d;
        end
    end

    assign bus.start_ready = (state_q == ST_IDLE);
    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.rk_valid    = rk_valid_q;
    assign bus.rk_data     = rk_data_q;
    assign bus.rk_idx      = rk_idx_q;
    assign bus.rk_last     = rk_valid_q && rk_last_q;
    assign bus.err         = err_q;

endmodule
